// File: rtl/core_bus_pkg.sv
// Shared 6502 system-bus types and the OAM DMA state encoding.
package core_bus_pkg;

    typedef logic [15:0] bus_addr_t;
    typedef logic [7:0]  bus_data_t;

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, GET, PUT} oam_dma_state_t;

    localparam bus_addr_t ADDR_OAMDMA  = 16'h4014;
    localparam bus_addr_t ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and system-side bus signals seen by the sprite DMA.
interface oam_dma_if;
    import core_bus_pkg::*;

    bus_addr_t I_cpu_addr;
    bus_data_t I_cpu_wr_data;
    logic      I_cpu_rdwr;
    logic      O_cpu_ready;
    bus_addr_t O_addr;
    bus_data_t O_wr_data;
    logic      O_rdwr;
    bus_data_t I_rd_data;
    logic      O_busy;

    modport slave (
        input  I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data,
        output O_cpu_ready, O_addr, O_wr_data, O_rdwr, O_busy
    );

    modport master (
        output I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data,
        input  O_cpu_ready, O_addr, O_wr_data, O_rdwr, O_busy
    );

endinterface

// File: rtl/oam_dma_bus_mux.sv
// Combinational CPU/DMA bus select driven by the DMA state.
module bus_mux
    import core_bus_pkg::*;
(
    input  oam_dma_state_t state,
    input  bus_addr_t      cpu_addr,
    input  bus_data_t      cpu_wr_data,
    input  logic           cpu_rdwr,
    input  bus_addr_t      dma_rd_addr,
    input  bus_addr_t      dma_wr_addr,
    input  bus_data_t      dma_data,
    output bus_addr_t      addr,
    output bus_data_t      wr_data,
    output logic           rdwr
);

    always_comb begin
        addr    = cpu_addr;
        wr_data = cpu_wr_data;
        rdwr    = cpu_rdwr;
        case (state)
            // halted core keeps re-issuing its read; never let a write escape
            HALT, ALIGN: rdwr = 1'b1;
            GET: begin
                addr = dma_rd_addr;
                rdwr = 1'b1;
            end
            PUT: begin
                addr    = dma_wr_addr;
                wr_data = dma_data;
                rdwr    = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/oam_dma.sv
// 2A03-style sprite DMA: a CPU write to $4014 halts the core and copies a page to $2004.
// Optional stall counter output enabled by defining OAM_DMA_STALL_COUNT_EN.
module oam_dma
    import core_bus_pkg::*;
#(
    parameter bus_addr_t DMA_REG_ADDR  = ADDR_OAMDMA,
    parameter bus_addr_t OAM_DATA_ADDR = ADDR_OAMDATA,
    parameter int        XFER_COUNT    = 256
) (
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic       I_cycle,
    oam_dma_if.slave   bus
`ifdef OAM_DMA_STALL_COUNT_EN
    ,
    output logic [15:0] O_stall_cycles
`endif
);

    localparam int IDX_W = (XFER_COUNT > 1) ? $clog2(XFER_COUNT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_COUNT - 1);

    oam_dma_state_t   state_q, state_d;
    bus_data_t        page_q, page_d;
    logic [IDX_W-1:0] index_q, index_d;
    bus_data_t        data_q, data_d;
    logic             parity_q, parity_d;
    logic             ready_q, ready_d;

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_q  <= IDLE;
            page_q   <= '0;
            index_q  <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        data_d   = data_q;
        ready_d  = ready_q;
        parity_d = parity_q ^ I_cycle;
        if (I_cycle) begin
            case (state_q)
                IDLE: begin
                    if (bus.I_cpu_addr == DMA_REG_ADDR && !bus.I_cpu_rdwr) begin
                        page_d  = bus.I_cpu_wr_data;
                        index_d = '0;
                        ready_d = 1'b0;
                        state_d = HALT;
                    end
                end
                // parity 1 now means the next cycle is a get cycle
                HALT:  state_d = parity_q ? GET : ALIGN;
                ALIGN: state_d = GET;
                GET: begin
                    data_d  = bus.I_rd_data;
                    state_d = PUT;
                end
                PUT: begin
                    if (index_q == IDX_LAST) begin
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = GET;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.O_cpu_ready = ready_q;
    assign bus.O_busy      = (state_q != IDLE);

    bus_mux u_bus_mux (
        .state       (state_q),
        .cpu_addr    (bus.I_cpu_addr),
        .cpu_wr_data (bus.I_cpu_wr_data),
        .cpu_rdwr    (bus.I_cpu_rdwr),
        .dma_rd_addr ({page_q, 8'(index_q)}),
        .dma_wr_addr (OAM_DATA_ADDR),
        .dma_data    (data_q),
        .addr        (bus.O_addr),
        .wr_data     (bus.O_wr_data),
        .rdwr        (bus.O_rdwr)
    );

`ifdef OAM_DMA_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    always_ff @(posedge I_clock) begin
        if (I_reset) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    always_comb begin
        stall_d = stall_q;
        if (I_cycle && !ready_q && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    assign O_stall_cycles = stall_q;
`endif

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite-DMA (OAMDMA, $4014) controller that sits directly downstream of the 6502 core's bus outputs and upstream of the system bus.
- Passes CPU address, data and direction through when idle.
- On a CPU write to $4014 it halts the core via its ready input, then copies 256 bytes from page $pp00–$ppFF to the OAM data port $2004.
- Matches 2A03 cycle behaviour: 513 or 514 stall cycles.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every put cycle.
- XFER_COUNT, 256, bytes per transfer (power of two, max 256).

Ports:
- I_clock  in  1  system clock.
- I_reset  in  1  synchronous, active-high reset.
- I_cycle  in  1  one-clock strobe marking the end of each CPU bus cycle; comes from the system timing generator and is independent of O_cpu_ready.
- I_cpu_addr  in  16  core address output.
- I_cpu_wr_data  in  8  core write data.
- I_cpu_rdwr  in  1  core direction; 1 = read, 0 = write.
- O_cpu_ready  out  1  to core ready input; 0 = core halted.
- O_addr  out  16  system bus address.
- O_wr_data  out  8  system bus write data.
- O_rdwr  out  1  system bus direction; 1 = read.
- I_rd_data  in  8  system bus read data, valid at I_cycle.
- O_busy  out  1  DMA owns the bus (states HALT..PUT).

Behaviour:
- All state changes happen only on clocks where I_cycle=1, except reset.
- Reset (takes precedence over everything, including mid-transfer):
  - state=IDLE, O_cpu_ready=1, O_busy=0, page=0, index=0, data=0, parity=0.
  - Bus outputs pass through combinationally from the CPU inputs.
  - An in-progress transfer is abandoned; no further $2004 writes occur.
- parity: 1-bit register toggled on every I_cycle; 0 = get (even) cycle, 1 = put (odd) cycle. It is never cleared except by reset.
- IDLE:
  - Bus outputs = CPU inputs.
  - On I_cycle with I_cpu_addr==DMA_REG_ADDR and I_cpu_rdwr==0: latch page=I_cpu_wr_data, index=0, O_cpu_ready<=0, go to HALT.
  - The $4014 write itself is still passed through to the bus.
- HALT, one cycle:
  - Bus outputs = CPU inputs, forced to a read (O_rdwr=1), because the core repeats its read while halted.
  - At I_cycle: if parity==1 (next cycle is even), go to GET; otherwise go to ALIGN.
- ALIGN, one cycle: same bus behaviour as HALT; go to GET.
- GET:
  - O_addr={page,index}, O_rdwr=1.
  - At I_cycle: data<=I_rd_data, go to PUT.
- PUT:
  - O_addr=OAM_DATA_ADDR, O_wr_data=data, O_rdwr=0.
  - At I_cycle: if index==XFER_COUNT-1, set O_cpu_ready<=1 and go to IDLE; otherwise index<=index+1 and go to GET.
- Cycle counts:
  - Total stall cycles = 1 HALT + ALIGN (0 or 1) + 2*XFER_COUNT, i.e. 513 or 514 with defaults.
  - The core resumes on the cycle after the last PUT.
- Index width: log2(XFER_COUNT) bits; it never wraps past the page boundary.
- Outside PUT, O_wr_data equals I_cpu_wr_data.
- A write to DMA_REG_ADDR seen while not in IDLE is ignored. The core is halted then, so this only arises from stimulus error.
- A CPU read of DMA_REG_ADDR has no effect.
- O_busy=1 in HALT, ALIGN, GET and PUT.

Optional Feature:
- Macro: OAM_DMA_STALL_COUNT_EN.
- When defined:
  - Adds output O_stall_cycles (16 bits), incremented on every I_cycle where O_cpu_ready==0.
  - Saturates at 16'hFFFF and is cleared only by reset. Used by the cycle-accuracy benches.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package core_bus_pkg holds:
  - typedef bus_addr_t (16 bits) and bus_data_t (8 bits).
  - enum oam_dma_state_t {IDLE, HALT, ALIGN, GET, PUT}.
  - Constants ADDR_OAMDMA=16'h4014 and ADDR_OAMDATA=16'h2004.
- One natural sub-module, bus_mux: purely combinational CPU/DMA bus select driven by state. The FSM, counters and data latch stay in oam_dma.

Test Plan:
1. Reset mid-transfer: after 100 cycles of DMA, pulse I_reset -> O_cpu_ready=1 and O_busy=0 on the next clock; no further writes to $2004.
2. Even-aligned trigger: CPU writes $02 to $4014 with parity such that HALT ends on parity 1 -> exactly 513 cycles with O_cpu_ready=0. The first get reads $0200, and 256 writes to $2004 carry mem[$0200..$02FF] in order.
3. Odd-aligned trigger: same as scenario 2 shifted by one cycle -> 514 stall cycles; one ALIGN cycle precedes the first get at $0200.
4. Page $FF with a pattern: mem[$FF00+i]=i^$A5 -> put data sequence $A5,$A4,... ; the last get address is $FFFF and no access to $0000 occurs.
5. Passthrough: CPU reads $4014 and writes $4015 -> no DMA, O_cpu_ready stays 1, and bus outputs equal the CPU inputs every cycle.
6. With OAM_DMA_STALL_COUNT_EN defined: two back-to-back DMAs, even then odd aligned -> O_stall_cycles=1027.
